// File: rtl/round_ctrl.sv
// round_ctrl: memory-game round sequencer (random pattern playback, player input check, scoring)
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a round (accepted only when idle or showing a result)
//   level[2:0]        difficulty 1..3, anything else plays as 1
//   tick              timebase strobe for playback and input timeout
//   in_valid, in_idx  one-cycle player entry of a button index
//   busy              round in progress
//   led_on, led_idx   currently displayed pattern element
//   input_en          waiting for player entries
//   done, pass, score round result, held until the next start or reset
module round_ctrl #(
    parameter int          ON_TICKS      = 2,
    parameter int          OFF_TICKS     = 1,
    parameter int          TIMEOUT_TICKS = 20,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] level,
    input  logic       tick,
    input  logic       in_valid,
    input  logic [2:0] in_idx,
    output logic       busy,
    output logic       led_on,
    output logic [2:0] led_idx,
    output logic       input_en,
    output logic       done,
    output logic       pass,
    output logic [4:0] score
);
    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, RESULT} state_t;
    localparam logic [15:0] ON_LAST  = 16'(ON_TICKS - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_TICKS - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);
    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] timer;
    logic [2:0]  pat [16];
    logic [3:0]  cnt;
    logic [3:0]  len_m1;
    logic [1:0]  lv;
    assign lv = (level == 3'd2 || level == 3'd3) ? level[1:0] : 2'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            timer    <= '0;
            cnt      <= '0;
            len_m1   <= '0;
            busy     <= 1'b0;
            led_on   <= 1'b0;
            led_idx  <= '0;
            input_en <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            score    <= '0;
            for (int i = 0; i < 16; i++) pat[i] <= '0;
        end else begin
            // Fibonacci LFSR, taps 16,14,13,11, free-running in every state
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            case (state)
                IDLE, RESULT: if (start) begin
                    state  <= GEN;
                    cnt    <= '0;
                    score  <= '0;
                    pass   <= 1'b0;
                    done   <= 1'b0;
                    busy   <= 1'b1;
                    // len-1 = 4*lv+3 for len = 4+4*lv
                    len_m1 <= {lv, 2'b11};
                end
                GEN: begin
                    pat[cnt] <= lfsr[2:0];
                    cnt      <= cnt + 4'd1;
                    if (cnt == len_m1) begin
                        state   <= SHOW_ON;
                        cnt     <= '0;
                        timer   <= '0;
                        led_on  <= 1'b1;
                        led_idx <= pat[0];
                    end
                end
                SHOW_ON: if (tick) begin
                    if (timer == ON_LAST) begin
                        state   <= SHOW_OFF;
                        timer   <= '0;
                        led_on  <= 1'b0;
                        led_idx <= '0;
                    end else timer <= timer + 16'd1;
                end
                SHOW_OFF: if (tick) begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (cnt == len_m1) begin
                            state    <= INPUT;
                            cnt      <= '0;
                            input_en <= 1'b1;
                        end else begin
                            state   <= SHOW_ON;
                            cnt     <= cnt + 4'd1;
                            led_on  <= 1'b1;
                            led_idx <= pat[cnt + 4'd1];
                        end
                    end else timer <= timer + 16'd1;
                end
                INPUT: begin
                    // a player entry wins over a simultaneous tick and restarts the timeout
                    if (in_valid) begin
                        timer <= '0;
                        if (in_idx == pat[cnt]) begin
                            score <= score + 5'd1;
                            if (cnt == len_m1) begin
                                state    <= RESULT;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                input_en <= 1'b0;
                                pass     <= 1'b1;
                            end else cnt <= cnt + 4'd1;
                        end else begin
                            state    <= RESULT;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            input_en <= 1'b0;
                        end
                    end else if (tick) begin
                        if (timer == TO_LAST) begin
                            state    <= RESULT;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            input_en <= 1'b0;
                        end else timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: randomized self-checking bench for round_ctrl against a pattern/score reference model
module tb_round_ctrl;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int ON = 2, OFF = 1, TO = 20;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, tick = 1'b0, in_valid = 1'b0;
    logic [2:0] level = '0, in_idx = '0;
    logic       busy, led_on, input_en, done, pass;
    logic [2:0] led_idx;
    logic [4:0] score;
    logic [15:0] m_lfsr;
    int n_chk = 0, n_err = 0;
    round_ctrl #(.ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .level(level), .tick(tick),
        .in_valid(in_valid), .in_idx(in_idx), .busy(busy), .led_on(led_on),
        .led_idx(led_idx), .input_en(input_en), .done(done), .pass(pass), .score(score)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return (v >> 1) | (16'(fb) << 15);
    endfunction
    // reference LFSR: seeded by reset, one step per clock otherwise
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run_round(input logic [2:0] lv, input bit rnd_tick, input int wrong_at, input bit feed);
        int len, eff, gen_n, n_lit, lit_n, off_n, bad_w, bad_gap, bad_idx, k, stop, exp_score;
        bit lit_prev, got_in, exp_pass;
        logic [2:0] pat [16];
        logic [15:0] v;
        logic [47:0] seen, want;
        eff = (lv == 3'd2 || lv == 3'd3) ? int'(lv) : 1;
        len = 4 + 4 * eff;
        @(negedge clk);
        v = m_lfsr;
        want = '0;
        for (int i = 0; i < len; i++) begin
            v = lfsr_step(v);
            pat[i] = v[2:0];
            want[i*3 +: 3] = v[2:0];
        end
        level = lv; start = 1'b1; in_valid = 1'b0;
        tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b1;
        gen_n = 0; n_lit = 0; lit_n = 0; off_n = 0; bad_w = 0; bad_gap = 0; bad_idx = 0;
        lit_prev = 1'b0; got_in = 1'b0; seen = '0;
        for (int c = 0; c < 3000 && !got_in; c++) begin
            @(negedge clk);
            if (input_en) begin
                got_in = 1'b1;
                if (off_n != OFF) bad_gap++;
            end else begin
                if (led_on) begin
                    if (!lit_prev) begin
                        if (n_lit < 16) seen[n_lit*3 +: 3] = led_idx;
                        if (n_lit > 0 && off_n != OFF) bad_gap++;
                        n_lit++;
                        lit_n = 0;
                    end
                    lit_n++;
                end else begin
                    if (lit_prev) begin
                        if (lit_n != ON) bad_w++;
                        off_n = 0;
                    end
                    off_n++;
                    if (n_lit == 0 && busy) gen_n++;
                    if (led_idx != 3'd0) bad_idx++;
                end
                lit_prev = led_on;
            end
            // start and in_valid must both be ignored outside IDLE/RESULT and INPUT respectively
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_idx = 3'($urandom);
            tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("reach_input", got_in, 1);
        if (!got_in) return;
        chk("gen_len", gen_n, len);
        chk("lit_count", n_lit, len);
        chk("pattern", seen, want);
        chk("dark_idx", bad_idx, 0);
        if (!rnd_tick) begin
            chk("lit_width", bad_w, 0);
            chk("gap_width", bad_gap, 0);
        end
        chk("input_flags", {busy, led_on, done}, 3'b100);
        if (feed) begin
            stop = (wrong_at >= 0) ? wrong_at : len - 1;
            exp_pass = (wrong_at < 0);
            exp_score = (wrong_at >= 0) ? wrong_at : len;
            for (int i = 0; i <= stop; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    start = 1'($urandom_range(0, 1));
                    tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                end
                start = 1'b0;
                in_valid = 1'b1;
                in_idx = (i == wrong_at) ? pat[i] ^ 3'($urandom_range(1, 7)) : pat[i];
                tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end
            chk("done_after_input", done, 1);
        end else begin
            exp_pass = 1'b0;
            exp_score = 0;
            in_valid = 1'b0; start = 1'b0; tick = 1'b1;
            k = 0;
            while (!done && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("timeout_cycles", k, TO);
        end
        chk("pass", pass, exp_pass);
        chk("score", score, exp_score);
        chk("result_flags", {busy, input_en, led_on, led_idx}, 0);
        repeat (3) begin
            start = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_idx = 3'($urandom);
            tick = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("result_hold", {done, pass, score}, {1'b1, exp_pass, 5'(exp_score)});
    endtask
    initial begin
        int lv, len, w;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_led_on", led_on, 0);
        chk("rst_led_idx", led_idx, 0);
        chk("rst_input_en", input_en, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_score", score, 0);
        rst = 1'b0;
        in_valid = 1'b1; tick = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_ignores_input", {busy, done, score}, 0);
        run_round(3'd1, 1'b0, -1, 1'b1);
        run_round(3'd2, 1'b1, 2, 1'b1);
        run_round(3'd3, 1'b0, -1, 1'b0);
        // reset in the middle of playback
        level = 3'd1; start = 1'b1; tick = 1'b1;
        for (int c = 0; c < 50 && !led_on; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("reach_show", led_on, 1);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("mid_rst", {busy, led_on, led_idx, input_en, done, pass, score}, 0);
        run_round(3'd0, 1'b0, -1, 1'b1);
        run_round(3'd7, 1'b1, 5, 1'b1);
        for (int r = 0; r < 6; r++) begin
            lv = $urandom_range(0, 7);
            len = (lv == 2 || lv == 3) ? 4 + 4 * lv : 8;
            w = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len - 1));
            run_round(3'(lv), 1'($urandom_range(0, 1)), w, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter ON_TICKS, default 2, ticks each pattern element is lit during playback.
REQ-002 Parameter OFF_TICKS, default 1, dark ticks after each lit element.
REQ-003 Parameter TIMEOUT_TICKS, default 20, ticks allowed between player inputs.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  begin a round; sampled only in IDLE or RESULT.
REQ-008 level  input  3  difficulty 1..3; any other value treated as 1.
REQ-009 tick  input  1  one-cycle timebase strobe for playback and timeout.
REQ-010 in_valid  input  1  one-cycle strobe: player entered one button index.
REQ-011 in_idx  input  3  entered button index 0..7, valid with in_valid.
REQ-012 busy  output  1  high in every state except IDLE and RESULT.
REQ-013 led_on  output  1  high while a pattern element is displayed.
REQ-014 led_idx  output  3  index of displayed element; 0 when led_on low.
REQ-015 input_en  output  1  high only in INPUT; enables the input capture path.
REQ-016 done  output  1  high while in RESULT.
REQ-017 pass  output  1  round result, valid while done high.
REQ-018 score  output  5  count of correct inputs this round, 0..16.

Function
REQ-019 Round length len SHALL be 4 + 4*level: 8, 12, 16; latched from level when start accepted.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock in every state.
REQ-021 Pattern store SHALL be 16 entries x 3 bits, plus 4-bit element counter cnt and tick counter.
REQ-022 States SHALL be IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, RESULT.
REQ-023 IDLE/RESULT + start: next cycle GEN, cnt=0, score=0, pass=0.
REQ-024 GEN: each cycle pat[cnt] <= lfsr[2:0], cnt++; after writing entry len-1 -> SHOW_ON, cnt=0; GEN lasts exactly len cycles.
REQ-025 SHOW_ON: led_on=1, led_idx=pat[cnt]; after ON_TICKS tick strobes -> SHOW_OFF.
REQ-026 SHOW_OFF: led_on=0; after OFF_TICKS strobes: cnt==len-1 -> INPUT, cnt=0, timer=0; else cnt++ -> SHOW_ON.
REQ-027 INPUT, in_valid with in_idx==pat[cnt]: score++, timer=0; cnt==len-1 -> RESULT pass=1, else cnt++.
REQ-028 INPUT, in_valid with in_idx!=pat[cnt]: -> RESULT, pass=0, score unchanged.
REQ-029 INPUT, timer reaching TIMEOUT_TICKS strobes with no in_valid -> RESULT, pass=0.
REQ-030 in_valid and tick in the same cycle: in_valid evaluated, timer cleared, tick not counted.
REQ-031 in_valid outside INPUT SHALL be ignored; start outside IDLE/RESULT SHALL be ignored.
REQ-032 RESULT SHALL hold done, pass, score stable until start or rst.
REQ-033 tick outside SHOW_ON, SHOW_OFF, INPUT SHALL have no effect.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE; busy, led_on, led_idx, input_en, done, pass, score, cnt, timer = 0; lfsr=SEED; all pat entries 0.
REQ-035 rst SHALL take priority over start, in_valid and tick in the same cycle, including mid-round.

Verification
REQ-036 rst=1 two cycles -> all outputs 0, state IDLE, lfsr=16'hACE1.
REQ-037 level=1, tick tied 1, start pulse, bench-modelled LFSR answers fed -> GEN 8 cycles, 8 lit windows of 2 cycles each with 1-cycle gaps, done=1, pass=1, score=8.
REQ-038 level=2, third input wrong -> done=1 next cycle, pass=0, score=2.
REQ-039 level=3, tick tied 1, no inputs -> RESULT 20 cycles after INPUT entry, pass=0, score=0.
REQ-040 rst pulsed during SHOW_ON -> next cycle IDLE, led_on=0, busy=0; in_valid during SHOW and start during INPUT -> no state/score change.
REQ-041 level=0 and level=7 -> len=8 round behaviour identical to level=1.
